// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and checks them.
// Optional macro SYSID_CHECKER_TIMEOUT_EN bounds the waitrequest stall per read.
module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1380672277,
  parameter int          READ_LATENCY       = 0,
  parameter int          START_DELAY        = 16,
  parameter int          MAX_RETRIES        = 3,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, DELAY, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               avm_read_q, avm_read_d;
  logic               avm_address_q, avm_address_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic [31:0]        id_q, id_d;
  logic [31:0]        ts_q, ts_d;
  logic               accept;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0]    to_q, to_d;
`endif

  assign accept = avm_read_q & ~avm_waitrequest;

  always_comb begin
    state_d       = state_q;
    dly_d         = dly_q;
    lat_d         = lat_q;
    retry_d       = retry_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    id_d          = id_q;
    ts_d          = ts_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          retry_d       = '0;
          busy_d        = 1'b1;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          state_d       = RD_ID;
        end
      end
      DELAY: begin
        if (dly_q == '0) begin
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          state_d       = RD_ID;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      RD_ID: begin
        // Read is raised here only when the state was entered with it low.
        if (!avm_read_q) begin
          avm_read_d = 1'b1;
        end else if (accept) begin
          avm_read_d = 1'b0;
          if (READ_LATENCY == 0) begin
            id_d          = avm_readdata;
            avm_address_d = 1'b1;
            state_d       = RD_TS;
          end else begin
            lat_d   = LAT_W'(READ_LATENCY - 1);
            state_d = LAT_ID;
          end
        end
      end
      LAT_ID: begin
        if (lat_q == '0) begin
          id_d          = avm_readdata;
          avm_address_d = 1'b1;
          state_d       = RD_TS;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RD_TS: begin
        if (!avm_read_q) begin
          avm_read_d = 1'b1;
        end else if (accept) begin
          avm_read_d = 1'b0;
          if (READ_LATENCY == 0) begin
            ts_d    = avm_readdata;
            state_d = CHECK;
          end else begin
            lat_d   = LAT_W'(READ_LATENCY - 1);
            state_d = LAT_TS;
          end
        end
      end
      LAT_TS: begin
        if (lat_q == '0) begin
          ts_d    = avm_readdata;
          state_d = CHECK;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      CHECK: begin
        if (id_q == EXPECTED_ID && ts_q == EXPECTED_TIMESTAMP) begin
          pass_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
          retry_d       = retry_q + 1'b1;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          state_d       = RD_ID;
        end else begin
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef SYSID_CHECKER_TIMEOUT_EN
    // A stalled read that hits the limit aborts the whole check without retry.
    to_d = to_q;
    if (accept) begin
      to_d = '0;
    end else if (avm_read_q && avm_waitrequest) begin
      if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_d       = '0;
        avm_read_d = 1'b0;
        fail_d     = 1'b1;
        pass_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = FINISH;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= DELAY;
      dly_q         <= DLY_W'(START_DELAY - 1);
      lat_q         <= '0;
      retry_q       <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      id_q          <= '0;
      ts_q          <= '0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
      to_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      dly_q         <= dly_d;
      lat_q         <= lat_d;
      retry_q       <= retry_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      id_q          <= id_d;
      ts_q          <= ts_d;
`ifdef SYSID_CHECKER_TIMEOUT_EN
      to_q          <= to_d;
`endif
    end
  end

  assign avm_address     = avm_address_q;
  assign avm_read        = avm_read_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail            = fail_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;

endmodule
